instr_decode: RTL

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/instr_decode.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Decodes SPI command frames into register-file read/write strobes.
// A frame is one command byte followed by one data byte (write) or one dummy
// byte (read). Any further bytes in the frame are ignored until chip select
// drops.
//
// Command byte: [7] rw (1 write, 0 read), [6] byte select (1 low, 0 high),
//               [5:0] base address. A high-byte access targets base+1 mod 64.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   frame_active in   SPI chip select asserted; low aborts the transaction
//   byte_sync    in   one-cycle pulse, data_in valid
//   data_in      in   [7:0] byte received from the SPI bridge
//   data_out     out  [7:0] byte to shift out on MISO during the next SPI byte
//   read         out  one-cycle register-file read strobe
//   write        out  one-cycle register-file write strobe
//   addr         out  [5:0] register-file byte address
//   data_read    in   [7:0] register-file read data, valid the cycle after read
//   data_write   out  [7:0] register-file write data, valid while write is high
// -----------------------------------------------------------------------------
module instr_decode (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_active,
  input  logic       byte_sync,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  input  logic [7:0] data_read,
  output logic [7:0] data_write
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] ST_CMD   = 2'd0;
  localparam logic [SW-1:0] ST_WDATA = 2'd1;
  localparam logic [SW-1:0] ST_RDATA = 2'd2;
  localparam logic [SW-1:0] ST_DRAIN = 2'd3;

  logic [SW-1:0] state_q,      state_d;
  logic [AW-1:0] addr_q,       addr_d;
  logic          read_q,       read_d;
  logic          write_q,      write_d;
  logic          rd_pend_q,    rd_pend_d;
  logic [DW-1:0] data_write_q, data_write_d;
  logic [DW-1:0] data_out_q,   data_out_d;

  // Effective address of a command byte; the 6-bit add wraps modulo 64.
  logic [AW-1:0] eff_addr_c;
  assign eff_addr_c = data_in[6] ? data_in[AW-1:0]
                                 : AW'(data_in[AW-1:0] + AW'(1));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CMD;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      data_write_q <= '0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      write_q      <= write_d;
      rd_pend_q    <= rd_pend_d;
      data_write_q <= data_write_d;
      data_out_q   <= data_out_d;
    end
  end

  // Next-state and strobe generation.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    data_write_d = data_write_q;
    data_out_d   = data_out_q;
    // data_read is valid the cycle after the read strobe; capture it then.
    rd_pend_d    = read_q;
    if (rd_pend_q) begin
      data_out_d = data_read;
    end

    // Chip select low wins over a coincident byte_sync: byte is discarded.
    if (!frame_active) begin
      state_d = ST_CMD;
    end else if (byte_sync) begin
      case (state_q)
        ST_CMD: begin
          addr_d = eff_addr_c;
          if (data_in[7]) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_RDATA;
            read_d  = 1'b1;
          end
        end
        ST_WDATA: begin
          write_d      = 1'b1;
          data_write_d = data_in;
          state_d      = ST_DRAIN;
        end
        ST_RDATA: begin
          state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          state_d = ST_DRAIN;
        end
        default: begin
          state_d = ST_CMD;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign data_write = data_write_q;

endmodule
